alu_share_ctrl: RTL and testbench

- Sequencer and arbiter that shares one 4-bit combinational ALU slice between two requesters.
- Each requester hands over an operand pair (A, B) and a 4-bit function select (S) through a valid/ready handshake.
- The block round-robin arbitrates, registers the winner's operands, and drives them onto the ALU for one execute cycle.
- It captures the ALU result E and returns it to the winning requester on a valid/ready response channel.
- Sits between the lab's datapath users and the single shared ALU instance.

---
 rtl/alu_share_pkg.sv | 19 +
 rtl/rr_arb2.sv | 28 ++
 rtl/alu_share_ctrl.sv | 112 +++++++++++
 tb/tb_alu_share_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// ---------------------------------------------------------------------------
// Module  : alu_share_pkg
// Brief   : Shared FSM encoding and width defaults for the shared-ALU sequencer
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu_share_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_SEL_W  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// Module  : rr_arb2
// Brief   : Two-way combinational priority arbiter; prio selects the preferred
//           requester, the caller owns the rotating pointer
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (prio == 1'b0) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : alu_share_ctrl
// Brief   : Round-robin sequencer sharing one external combinational ALU slice
//           between two valid/ready requesters
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_s,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_s,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_s,
  input  logic [DATA_W-1:0] alu_e,
  output logic              busy
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_prio;
  logic              r_owner;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [SEL_W-1:0]  r_op_s;
  logic [DATA_W-1:0] r_resp_data;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_resp_take;

  rr_arb2 u_arb (
    .req   ({req1_valid, req0_valid}),
    .prio  (r_prio),
    .grant (w_grant)
  );

  // Grant is only meaningful in IDLE; the ready outputs qualify it with state.
  assign w_accept    = (r_state == IDLE) &&
                       ((req0_valid && w_grant[0]) || (req1_valid && w_grant[1]));
  assign w_resp_take = (r_state == RESP) && (r_owner ? resp1_ready : resp0_ready);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_resp_take) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = (r_state == IDLE) && w_grant[0];
    req1_ready  = (r_state == IDLE) && w_grant[1];
    resp0_valid = (r_state == RESP) && !r_owner;
    resp1_valid = (r_state == RESP) &&  r_owner;
    busy        = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_s      <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant[1];
        r_op_a  <= w_grant[1] ? req1_a : req0_a;
        r_op_b  <= w_grant[1] ? req1_b : req0_b;
        r_op_s  <= w_grant[1] ? req1_s : req0_s;
      end
      if (r_state == EXEC) r_resp_data <= alu_e;
      if (w_resp_take)     r_prio      <= ~r_owner;
    end
  end

  assign alu_a     = r_op_a;
  assign alu_b     = r_op_b;
  assign alu_s     = r_op_s;
  assign resp_data = r_resp_data;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : tb_alu_share_ctrl
// Brief   : Self-checking bench for alu_share_ctrl with a closed-loop ALU model
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req0_s, req1_a, req1_b, req1_s;
  logic       resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [3:0] resp_data, alu_a, alu_b, alu_s, alu_e;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Logic-mode ALU slice; select codes map onto the classic 74181 logic table.
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s);
    case (s ^ 4'hC)
      4'h0: alu_ref = ~a;
      4'h1: alu_ref = ~(a | b);
      4'h2: alu_ref = ~a & b;
      4'h3: alu_ref = 4'h0;
      4'h4: alu_ref = ~(a & b);
      4'h5: alu_ref = ~b;
      4'h6: alu_ref = a ^ b;
      4'h7: alu_ref = a & ~b;
      4'h8: alu_ref = ~a | b;
      4'h9: alu_ref = ~(a ^ b);
      4'hA: alu_ref = b;
      4'hB: alu_ref = a & b;
      4'hC: alu_ref = 4'hF;
      4'hD: alu_ref = a | ~b;
      4'hE: alu_ref = a | b;
      default: alu_ref = a;
    endcase
  endfunction

  assign alu_e = alu_ref(alu_a, alu_b, alu_s);

  alu_share_ctrl #(.DATA_W(4), .SEL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_e(alu_e),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_s = 0; req1_a = 0; req1_b = 0; req1_s = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({busy, resp0_valid, resp1_valid, req0_ready, req1_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=00000",
               {busy, resp0_valid, resp1_valid, req0_ready, req1_ready});
    end
    req0_valid = 1; req0_a = 4'h5; req0_b = 4'h3; req0_s = 4'h6;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_accept got=%b want=1", req0_ready);
    end
    tick();
    req0_valid = 0;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_exec_busy got=%b want=1", busy);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, resp0_valid, resp1_valid, alu_a, alu_b, alu_s} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_midexec got busy=%b rv=%b%b alu=%h%h%h want all zero",
               busy, resp1_valid, resp0_valid, alu_a, alu_b, alu_s);
    end
    tick();
    rst = 1'b0; resp0_ready = 1; resp1_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if ({resp0_valid, resp1_valid, busy} !== 3'b0) begin
        n_fail++;
        $display("FAIL reset_no_resp cyc=%0d got=%b want=000", i,
                 {resp0_valid, resp1_valid, busy});
      end
      tick();
    end
    resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic test_prio_after_reset();
    do_reset();
    req0_valid = 1; req1_valid = 1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_after_reset got r0r1=%b%b want=10", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_single_op();
    do_reset();
    req0_valid = 1; req0_a = 4'hC; req0_b = 4'hA; req0_s = 4'h8;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready got=%b%b want=10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0;
    #1;
    n_checks++;
    if ({alu_a, alu_b, alu_s, resp0_valid} !== {4'hC, 4'hA, 4'h8, 1'b0}) begin
      n_fail++;
      $display("FAIL single_exec got alu=%h%h%h rv0=%b want=CA8 0",
               alu_a, alu_b, alu_s, resp0_valid);
    end
    tick();
    n_checks++;
    if ({resp0_valid, resp1_valid, resp_data} !== {2'b10, 4'h7}) begin
      n_fail++;
      $display("FAIL single_resp got rv=%b%b data=%h want=10 7",
               resp0_valid, resp1_valid, resp_data);
    end
    resp0_ready = 1;
    tick();
    resp0_ready = 0;
    n_checks++;
    if ({busy, resp0_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_done got=%b%b want=00", busy, resp0_valid);
    end
  endtask

  task automatic test_functions();
    logic [3:0] sels [3] = '{4'h4, 4'h0, 4'hC};
    logic [3:0] exps [3] = '{4'hB, 4'hF, 4'h3};
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_a = 4'hC; req0_b = 4'hA; req0_s = sels[i];
      tick();
      req0_valid = 0;
      tick();
      n_checks++;
      if ({resp0_valid, resp_data} !== {1'b1, exps[i]}) begin
        n_fail++;
        $display("FAIL func_s%h got v=%b data=%h want v=1 data=%h",
                 sels[i], resp0_valid, resp_data, exps[i]);
      end
      resp0_ready = 1;
      tick();
      resp0_ready = 0;
    end
  endtask

  task automatic test_arbitration();
    int g_cyc [$];
    int g_who [$];
    do_reset();
    req0_a = 4'h1; req0_b = 4'h2; req0_s = 4'h3;
    req1_a = 4'h9; req1_b = 4'h6; req1_s = 4'hE;
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready) begin g_cyc.push_back(c); g_who.push_back(0); end
      if (req1_ready) begin g_cyc.push_back(c); g_who.push_back(1); end
      if (resp0_valid || resp1_valid) begin
        n_checks++;
        if (resp_data !== (resp1_valid ? alu_ref(4'h9, 4'h6, 4'hE)
                                        : alu_ref(4'h1, 4'h2, 4'h3))) begin
          n_fail++;
          $display("FAIL arb_data cyc=%0d got=%h owner1=%b", c, resp_data, resp1_valid);
        end
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    n_checks++;
    if (g_cyc.size() != 4) begin
      n_fail++; $display("FAIL arb_count got=%0d want=4", g_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (g_who[k] != (k % 2) || g_cyc[k] != 3 * k) begin
          n_fail++;
          $display("FAIL arb_grant%0d got who=%0d cyc=%0d want who=%0d cyc=%0d",
                   k, g_who[k], g_cyc[k], k % 2, 3 * k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_d;
    do_reset();
    exp_d = alu_ref(4'h7, 4'hC, 4'h9);
    req1_valid = 1; req1_a = 4'h7; req1_b = 4'hC; req1_s = 4'h9;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept got=%b want=1", req1_ready);
    end
    tick();
    req1_valid = 0; req0_valid = 1; req0_a = 4'h2; req0_b = 4'h4; req0_s = 4'hE;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({resp1_valid, resp0_valid, req0_ready, resp_data} !== {3'b100, exp_d}) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v1=%b v0=%b r0=%b data=%h want 1 0 0 %h",
                 i, resp1_valid, resp0_valid, req0_ready, resp_data, exp_d);
      end
      tick();
    end
    resp1_ready = 1;
    tick();
    resp1_ready = 0;
    #1;
    n_checks++;
    if ({busy, req0_ready, resp1_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release got busy=%b r0=%b v1=%b want 0 1 0",
               busy, req0_ready, resp1_valid);
    end
    req0_valid = 0;
  endtask

  task automatic test_random();
    bit         outstanding = 0;
    bit         prio = 0;
    bit         owner = 0;
    int         age = 0;
    logic [3:0] exp_d = 0;
    bit         e_r0, e_r1, e_v0, e_v1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_s = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_s = 4'($urandom);
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_r0 = !outstanding && req0_valid && (!prio || !req1_valid);
      e_r1 = !outstanding && req1_valid && (prio || !req0_valid);
      e_v0 = outstanding && age >= 2 && !owner;
      e_v1 = outstanding && age >= 2 && owner;
      n_checks++;
      if ({req1_ready, req0_ready, resp1_valid, resp0_valid, busy} !==
          {e_r1, e_r0, e_v1, e_v0, outstanding}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", c,
                 {req1_ready, req0_ready, resp1_valid, resp0_valid, busy},
                 {e_r1, e_r0, e_v1, e_v0, outstanding});
      end
      if (outstanding && age >= 2) begin
        n_checks++;
        if (resp_data !== exp_d) begin
          n_fail++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, resp_data, exp_d);
        end
      end
      if (outstanding && age == 1) begin
        n_checks++;
        if (alu_e !== exp_d) begin
          n_fail++; $display("FAIL rand_alu cyc=%0d got=%h want=%h", c, alu_e, exp_d);
        end
      end
      if (outstanding) begin
        if (age >= 2 && (owner ? resp1_ready : resp0_ready)) begin
          outstanding = 0;
          prio = ~owner;
        end else begin
          age++;
        end
      end else if (e_r0 || e_r1) begin
        outstanding = 1;
        age = 1;
        owner = e_r1;
        exp_d = e_r1 ? alu_ref(req1_a, req1_b, req1_s) : alu_ref(req0_a, req0_b, req0_s);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
  endtask

  initial begin
    test_reset();
    test_prio_after_reset();
    test_single_op();
    test_functions();
    test_arbitration();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
